rv32i_alu_arbiter: RTL
======================

Name: rv32i_alu_arbiter

Overview:
Shares one combinational rv32i_alu instance between two requesters, e.g. the execute stage and a branch/address-generation helper. Requests use a valid/ready handshake. Arbitration is round-robin, with fixed priority available as an option. The arbiter latches the operands, drives the shared ALU and captures result plus flags into a registered per-requester response held until accepted. One operation is in flight at a time.

Parameters:
XLEN, 32, operand/result width; must match the ALU.
OP_W, 4, ALU opcode width; the opcode is opaque to the arbiter.
RR_ENABLE, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.

Ports:
clk  in  1  clock; all state on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  bit i: requester i presents an operation
req_ready  out  2  bit i: requester i's operation is accepted this cycle
req0_op  in  OP_W  requester 0 opcode
req0_a  in  XLEN  requester 0 operand a
req0_b  in  XLEN  requester 0 operand b
req1_op  in  OP_W  requester 1 opcode
req1_a  in  XLEN  requester 1 operand a
req1_b  in  XLEN  requester 1 operand b
rsp_valid  out  2  bit i: response for requester i is valid
rsp_ready  in  2  bit i: requester i accepts its response
rsp_result  out  XLEN  captured ALU result, shared by both requesters and qualified by rsp_valid
rsp_flags  out  3  captured {overflow, negative, zero}
alu_op  out  OP_W  to ALU op
alu_a  out  XLEN  to ALU a
alu_b  out  XLEN  to ALU b
alu_result  in  XLEN  from ALU result
alu_zero  in  1  from ALU zero_flag
alu_negative  in  1  from ALU negative_flag
alu_overflow  in  1  from ALU overflow_flag
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, owner=0, last_grant=1 (requester 0 wins first).
  - alu_op/alu_a/alu_b = 0, rsp_result = 0, rsp_flags = 0.
  - rsp_valid = 0, req_ready = 0, busy = 0.
  - Reset mid-operation discards the in-flight operation silently; no response is produced.
- IDLE:
  - req_ready is combinational: nonzero only in IDLE, and only for the grant winner.
  - Both valid, RR_ENABLE=1: winner = requester != last_grant.
  - Both valid, RR_ENABLE=0: winner = 0.
  - Single valid: that requester wins.
  - On grant: latch the winner's op/a/b into the alu_* registers, set owner = winner, go to EXEC.
  - No valid: stay in IDLE; the alu_* registers hold their previous values.
- EXEC (1 cycle):
  - The ALU settles from the registered inputs.
  - At the clock edge: rsp_result <= alu_result, rsp_flags <= {alu_overflow, alu_negative, alu_zero}, rsp_valid[owner] <= 1, go to RESP.
- RESP:
  - rsp_valid[owner] held high; rsp_result and rsp_flags held stable.
  - When rsp_ready[owner]=1: clear rsp_valid, last_grant <= owner, go to IDLE.
  - rsp_ready of the non-owner is ignored.
  - The response must never drop without a handshake.
- Latency and throughput:
  - Accept at cycle N → rsp_valid at N+2.
  - Minimum issue interval is 3 cycles, with rsp_ready tied high.
- Request rules:
  - Requests are not required to stay stable before acceptance. Only the values sampled in the accept cycle matter.
  - A requester may drop req_valid before acceptance without effect.
- Invariants:
  - req_ready is one-hot or zero, and is zero outside IDLE.
  - rsp_valid is one-hot or zero.
  - A request arriving while busy waits; it is granted in the first IDLE cycle after the response completes.
- Arithmetic: the arbiter does no arithmetic; results and flags pass through bit-exact from the ALU.

Test Plan:
- Single request: req0 ADD a=5, b=7 accepted at cycle N → rsp_valid=2'b01 at N+2, rsp_result=12, flags=000; rsp_ready=1 → IDLE next cycle.
- Simultaneous requests after reset: req0 ADD 1+1, req1 SUB 3-3 both valid.
  - Response order: req0 first (result 2), then req1 (result 0, zero flag set).
  - Acceptance cycles: req0 at N, req1 at N+3.
- Round-robin under continuous contention: both valid for 12 accepts → grants alternate 0,1,0,1…; with RR_ENABLE=0 all 12 go to requester 0.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles while req1 is valid.
  - rsp_valid and result stay stable; req_ready stays 0 throughout.
  - req1 is granted the cycle after the handshake.
- Flags: SUB 0x80000000 - 1 → result 0x7FFFFFFF with overflow set; SUB 1-2 → 0xFFFFFFFF with negative set.
- Reset mid-op: assert rst_n=0 in EXEC → all outputs 0 immediately; after release no stale rsp_valid appears, and req0 wins the next contention.

Source files
------------

// File: rtl/rv32i_alu_arbiter.sv
// Two-requester front end for one shared combinational RV32I ALU.
// Operands are registered into the ALU, and the result is captured into a held response.
module rv32i_alu_arbiter #(
  parameter int XLEN      = 32,
  parameter int OP_W      = 4,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [OP_W-1:0] req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic [2:0]      rsp_flags,
  output logic [OP_W-1:0] alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_negative,
  input  logic            alu_overflow,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]      rsp_flags_q, rsp_flags_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;

  logic winner;
  logic grant;

  always_comb begin
    winner = 1'b0;
    unique case (req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = RR_ENABLE ? ~last_grant_q : 1'b0;
      default: winner = 1'b0;
    endcase
    grant = (state_q == IDLE) && (|req_valid);
  end

  // Gated by rst_n so no requester sees an acceptance while reset is held.
  assign req_ready = (grant && rst_n) ? (2'b01 << winner) : 2'b00;

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_valid_d  = rsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = EXEC;
          owner_d  = winner;
          alu_op_d = winner ? req1_op : req0_op;
          alu_a_d  = winner ? req1_a  : req0_a;
          alu_b_d  = winner ? req1_b  : req0_b;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = {alu_overflow, alu_negative, alu_zero};
        rsp_valid_d  = 2'b01 << owner_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d  = 2'b00;
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = (state_q != IDLE);

endmodule
